// File: rtl/scoreboard_regfile.sv
// Register file with per-entry busy (pending-producer) flags, multi-port registered reads
// with write bypass, claim-collision reporting and a live count of busy registers.
module scoreboard_regfile #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall_flag,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       claim_en,
    input  logic [ADDR_W-1:0]          claim_addr,
    output logic                       claim_err,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [DATA_W-1:0]        mem_r [DEPTH];
    logic [DEPTH-1:0]         busy_r;
    logic [DEPTH-1:0]         busy_next_s;
    logic                     wr_ok_s;
    logic                     claim_ok_s;
    logic                     claim_err_next_s;
    logic [ADDR_W-1:0]        rd_a_s;
    logic [NUM_RD*DATA_W-1:0] rd_data_next_s;
    logic [NUM_RD-1:0]        rd_busy_next_s;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 32'sd0) && (a == ADDR_ZERO);
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = {(ADDR_W+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            c = c + (ADDR_W+1)'(v[i]);
        end
        return c;
    endfunction

    // Post-update busy flags: a claim overrides a same-address write clear.
    always_comb begin
        wr_ok_s     = wr_en && !is_zero_reg(wr_addr);
        claim_ok_s  = claim_en && !is_zero_reg(claim_addr);
        busy_next_s = busy_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (claim_ok_s && (claim_addr == ADDR_W'(i))) begin
                busy_next_s[i] = 1'b1;
            end else if (wr_ok_s && (wr_addr == ADDR_W'(i))) begin
                busy_next_s[i] = 1'b0;
            end else begin
                busy_next_s[i] = busy_r[i];
            end
        end
        claim_err_next_s = claim_ok_s && busy_r[claim_addr]
                           && !(wr_ok_s && (wr_addr == claim_addr));
    end

    // Read-port muxes with write bypass; busy always reflects this cycle's updates.
    always_comb begin
        rd_data_next_s = {(NUM_RD*DATA_W){1'b0}};
        rd_busy_next_s = {NUM_RD{1'b0}};
        rd_a_s         = ADDR_ZERO;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_a_s = rd_addr[k*ADDR_W +: ADDR_W];
            if (is_zero_reg(rd_a_s)) begin
                rd_data_next_s[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rd_busy_next_s[k]                  = 1'b0;
            end else if (wr_ok_s && (wr_addr == rd_a_s)) begin
                rd_data_next_s[k*DATA_W +: DATA_W] = wr_data;
                rd_busy_next_s[k]                  = busy_next_s[rd_a_s];
            end else begin
                rd_data_next_s[k*DATA_W +: DATA_W] = mem_r[rd_a_s];
                rd_busy_next_s[k]                  = busy_next_s[rd_a_s];
            end
        end
    end

    // Storage array and busy flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (wr_ok_s) begin
                mem_r[wr_addr] <= wr_data;
            end
            busy_r <= busy_next_s;
        end
    end

    // Registered outputs; stall freezes only the read ports.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data   <= {(NUM_RD*DATA_W){1'b0}};
            rd_busy   <= {NUM_RD{1'b0}};
            claim_err <= 1'b0;
            busy_cnt  <= {(ADDR_W+1){1'b0}};
        end else begin
            claim_err <= claim_err_next_s;
            busy_cnt  <= popcount(busy_next_s);
            if (!stall_flag) begin
                rd_data <= rd_data_next_s;
                rd_busy <= rd_busy_next_s;
            end
        end
    end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// Self-checking bench for scoreboard_regfile: directed vectors with literal expectations,
// an array-based reference model compared every cycle, and a wide 4-port instance.
module tb_scoreboard_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall_flag, wr_en, claim_en, claim_err;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [4:0]  wr_addr, claim_addr;
    logic [31:0] wr_data;
    logic [5:0]  busy_cnt;

    logic         b_stall, b_wr_en, b_claim_en, b_claim_err;
    logic [19:0]  b_rd_addr;
    logic [255:0] b_rd_data;
    logic [3:0]   b_rd_busy;
    logic [4:0]   b_wr_addr, b_claim_addr;
    logic [63:0]  b_wr_data;
    logic [5:0]   b_busy_cnt;

    scoreboard_regfile dut (
        .clk(clk), .reset(reset), .stall_flag(stall_flag), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .claim_en(claim_en), .claim_addr(claim_addr),
        .claim_err(claim_err), .busy_cnt(busy_cnt)
    );

    scoreboard_regfile #(.DATA_W(64), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1)) dut_w (
        .clk(clk), .reset(reset), .stall_flag(b_stall), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_busy(b_rd_busy), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .claim_en(b_claim_en), .claim_addr(b_claim_addr),
        .claim_err(b_claim_err), .busy_cnt(b_busy_cnt)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state (register contents and pending flags) and predicted outputs
    logic [31:0] m_mem [32];
    logic        m_busy [32];
    logic [63:0] e_data;
    logic [1:0]  e_busy;
    logic        e_err;
    logic [5:0]  e_cnt;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply the rules to the inputs that the coming posedge will see.
    task automatic model_step();
        logic was_busy;
        int   n;
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = 32'h0;
                m_busy[i] = 1'b0;
            end
            e_data = 64'h0; e_busy = 2'b00; e_err = 1'b0; e_cnt = 6'd0;
        end else begin
            was_busy = m_busy[claim_addr];
            if (wr_en && wr_addr != 5'd0) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            e_err = claim_en && (claim_addr != 5'd0) && was_busy
                    && !(wr_en && wr_addr == claim_addr);
            if (claim_en && claim_addr != 5'd0) m_busy[claim_addr] = 1'b1;
            n = 0;
            for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
            e_cnt = 6'(n);
            if (!stall_flag) begin
                for (int k = 0; k < 2; k++) begin
                    e_data[k*32 +: 32] = m_mem[rd_addr[k*5 +: 5]];
                    e_busy[k]          = m_busy[rd_addr[k*5 +: 5]];
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        chk("model_rd_data", rd_data, e_data);
        chk("model_rd_busy", rd_busy, e_busy);
        chk("model_claim_err", claim_err, e_err);
        chk("model_busy_cnt", busy_cnt, e_cnt);
    endtask

    initial begin
        reset = 1'b0; stall_flag = 1'b0; rd_addr = 10'd0;
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
        claim_en = 1'b0; claim_addr = 5'd0;
        b_stall = 1'b0; b_rd_addr = 20'd0; b_wr_en = 1'b0; b_wr_addr = 5'd0;
        b_wr_data = 64'h0; b_claim_en = 1'b0; b_claim_addr = 5'd0;
        tick(); tick();
        chk("reset_rd_data", rd_data, 64'h0);
        chk("reset_rd_busy", rd_busy, 2'b00);
        chk("reset_claim_err", claim_err, 1'b0);
        chk("reset_busy_cnt", busy_cnt, 6'd0);

        // read r4,r5 after reset; wide instance writes and claims r0
        reset = 1'b1; rd_addr = {5'd5, 5'd4};
        b_wr_en = 1'b1; b_wr_addr = 5'd0; b_wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        b_claim_en = 1'b1; b_claim_addr = 5'd0; b_rd_addr = 20'd0;
        tick();
        chk("r45_data", rd_data, 64'h0);
        chk("r45_busy", rd_busy, 2'b00);
        chk("r45_cnt", busy_cnt, 6'd0);
        chk("w_r0_data", b_rd_data, 256'h0);
        chk("w_r0_busy", b_rd_busy, 4'h0);
        chk("w_r0_cnt", b_busy_cnt, 6'd0);
        chk("w_r0_err", b_claim_err, 1'b0);

        // bypass of r7 on port 0; wide instance bypasses r6 on all four ports
        rd_addr = {5'd0, 5'd7}; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_00A5;
        b_claim_en = 1'b0; b_wr_addr = 5'd6; b_wr_data = 64'h0123_4567_89AB_CDEF;
        b_rd_addr = {4{5'd6}};
        tick();
        chk("bypass_r7", rd_data[31:0], 32'h0000_00A5);
        chk("w_bypass_r6", b_rd_data, {4{64'h0123_4567_89AB_CDEF}});

        wr_en = 1'b0; claim_en = 1'b1; claim_addr = 5'd3;
        b_wr_en = 1'b0; b_claim_en = 1'b1; b_claim_addr = 5'd6;
        tick();
        chk("claim_r3_cnt", busy_cnt, 6'd1);
        chk("w_claim_busy", b_rd_busy, 4'hF);
        chk("w_claim_cnt", b_busy_cnt, 6'd1);
        chk("w_claim_data", b_rd_data, {4{64'h0123_4567_89AB_CDEF}});

        claim_en = 1'b0; rd_addr = {5'd0, 5'd3};
        tick();
        chk("r3_busy", rd_busy[0], 1'b1);
        chk("r3_cnt", busy_cnt, 6'd1);
        chk("w_reclaim_err", b_claim_err, 1'b1);
        chk("w_reclaim_cnt", b_busy_cnt, 6'd1);

        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11; b_claim_en = 1'b0;
        tick();
        chk("r3_wr_busy", rd_busy[0], 1'b0);
        chk("r3_wr_data", rd_data[31:0], 32'h11);
        chk("r3_wr_cnt", busy_cnt, 6'd0);
        chk("w_err_clear", b_claim_err, 1'b0);

        // double claim of r3
        wr_en = 1'b0; claim_en = 1'b1; claim_addr = 5'd3;
        tick();
        chk("claim1_err", claim_err, 1'b0);
        tick();
        chk("claim2_err", claim_err, 1'b1);
        chk("claim2_cnt", busy_cnt, 6'd1);
        claim_en = 1'b0;
        tick();
        chk("claim_err_pulse", claim_err, 1'b0);

        // same-cycle claim+write of r9
        claim_en = 1'b1; claim_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9;
        wr_data = 32'h99; rd_addr = {5'd9, 5'd3};
        tick();
        chk("r9_busy", rd_busy, 2'b11);
        chk("r9_data", rd_data[63:32], 32'h99);
        chk("r9_cnt", busy_cnt, 6'd2);
        chk("r9_err", claim_err, 1'b0);

        claim_en = 1'b0; wr_en = 1'b0; rd_addr = {5'd9, 5'd7};
        tick();
        chk("pre_stall_data", rd_data, {32'h99, 32'h0000_00A5});
        chk("pre_stall_busy", rd_busy, 2'b10);

        // three stalled cycles: writes/claims proceed, read outputs hold
        stall_flag = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22; rd_addr = {5'd2, 5'd2};
        tick();
        chk("stall1_data", rd_data, {32'h99, 32'h0000_00A5});
        wr_addr = 5'd9; wr_data = 32'h55; rd_addr = {5'd4, 5'd5};
        tick();
        chk("stall2_busy", rd_busy, 2'b10);
        chk("stall2_cnt", busy_cnt, 6'd1);
        wr_en = 1'b0; claim_en = 1'b1; claim_addr = 5'd12; rd_addr = {5'd1, 5'd2};
        tick();
        chk("stall3_data", rd_data, {32'h99, 32'h0000_00A5});
        chk("stall3_cnt", busy_cnt, 6'd2);
        stall_flag = 1'b0; claim_en = 1'b0; rd_addr = {5'd9, 5'd2};
        tick();
        chk("unstall_data", rd_data, {32'h55, 32'h22});
        chk("unstall_busy", rd_busy, 2'b00);

        // register 0 is immune to writes and claims
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        claim_en = 1'b1; claim_addr = 5'd0; rd_addr = {5'd0, 5'd0};
        tick();
        chk("r0_data", rd_data, 64'h0);
        chk("r0_busy", rd_busy, 2'b00);
        chk("r0_cnt", busy_cnt, 6'd2);
        chk("r0_err", claim_err, 1'b0);

        // claim r5 while writing busy r12: net count unchanged
        claim_addr = 5'd5; wr_addr = 5'd12; wr_data = 32'hC; rd_addr = {5'd5, 5'd12};
        tick();
        chk("xy_data", rd_data, {32'h0, 32'hC});
        chk("xy_busy", rd_busy, 2'b10);
        chk("xy_cnt", busy_cnt, 6'd2);
        wr_en = 1'b0; claim_en = 1'b0; rd_addr = {5'd12, 5'd12};
        tick();
        chk("dup_port_data", rd_data, {32'hC, 32'hC});

        // reset wins over write, claim and stall
        reset = 1'b0; stall_flag = 1'b1; wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h77;
        claim_en = 1'b1; claim_addr = 5'd21; rd_addr = {5'd20, 5'd20};
        tick();
        chk("rst_mid_data", rd_data, 64'h0);
        chk("rst_mid_cnt", busy_cnt, 6'd0);
        reset = 1'b1; stall_flag = 1'b0; claim_en = 1'b0;
        tick();
        chk("post_rst_wr", rd_data, {32'h77, 32'h77});
        chk("post_rst_cnt", busy_cnt, 6'd0);
        wr_en = 1'b0; rd_addr = {5'd5, 5'd3};
        tick();
        chk("post_rst_clear", rd_data, 64'h0);
        chk("post_rst_busy", rd_busy, 2'b00);

        // pseudo-random traffic on a narrow address range for collisions
        for (int c = 0; c < 300; c++) begin
            reset      = ($urandom_range(0, 60) != 0);
            stall_flag = ($urandom_range(0, 3) == 0);
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = 5'($urandom_range(0, 7));
            wr_data    = $urandom;
            claim_en   = $urandom_range(0, 1) == 1;
            claim_addr = 5'($urandom_range(0, 7));
            rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scoreboard_regfile.md
SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter ADDR_W, default 5, address width; depth DEPTH = 2**ADDR_W.
REQ-003 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, 1 = register 0 hardwired to zero.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-007 stall_flag  input  1  1 = hold all read outputs.
REQ-008 rd_addr  input  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 rd_data  output  NUM_RD*DATA_W  packed registered read data; port k at [k*DATA_W +: DATA_W].
REQ-010 rd_busy  output  NUM_RD  registered busy flag of each port's addressed register.
REQ-011 wr_en  input  1  write strobe.
REQ-012 wr_addr  input  ADDR_W  write address.
REQ-013 wr_data  input  DATA_W  write data.
REQ-014 claim_en  input  1  marks claim_addr as pending (producer in flight).
REQ-015 claim_addr  input  ADDR_W  register being claimed.
REQ-016 claim_err  output  1  registered pulse: claim hit an already-busy register.
REQ-017 busy_cnt  output  ADDR_W+1  registered count of busy registers.

Function
REQ-018 Storage SHALL be DEPTH x DATA_W data plus DEPTH x 1 busy flags.
REQ-019 Write SHALL update mem[wr_addr] <= wr_data and clear busy[wr_addr] on posedge when wr_en=1.
REQ-020 Claim SHALL set busy[claim_addr] on posedge when claim_en=1.
REQ-021 Claim and write to the same address in one cycle: data written, busy ends SET (claim wins).
REQ-022 Claim and write to different addresses in one cycle: both take effect.
REQ-023 ZERO_REG=1: writes and claims to address 0 SHALL be ignored; address 0 reads data 0, busy 0; no claim_err.
REQ-024 Read latency SHALL be 1 cycle: rd_data/rd_busy valid on the posedge after rd_addr is presented with stall_flag=0.
REQ-025 Read bypass: when wr_en=1 and wr_addr equals rd_addr of port k (non-zero-reg), rd_data[k] SHALL load wr_data, not the old contents.
REQ-026 rd_busy[k] SHALL load the post-update flag (after this cycle's write and claim are applied).
REQ-027 stall_flag=1: rd_data and rd_busy SHALL hold; writes, claims, busy_cnt and claim_err continue updating.
REQ-028 claim_err SHALL be 1 for exactly the cycle after a claim to a register whose flag was already set and not cleared by a same-cycle write; else 0.
REQ-029 busy_cnt SHALL equal the number of set flags after each posedge; range 0..DEPTH, never wraps.
REQ-030 Simultaneous claim of X and write of Y with X!=Y SHALL net busy_cnt change of +1 (if X was clear) -1 (if Y was set).
REQ-031 Multiple read ports addressing the same register SHALL return identical data and busy.
REQ-032 Out-of-range addresses do not exist (full 2**ADDR_W decode).

Reset
REQ-033 reset=0 at posedge SHALL clear all mem entries, all busy flags, rd_data, rd_busy, claim_err and busy_cnt to 0.
REQ-034 Reset SHALL take priority over wr_en, claim_en and stall_flag in the same cycle.
REQ-035 Reset asserted mid-operation SHALL discard any in-flight write/claim of that cycle; first write accepted on the posedge after reset=1.

Verification
REQ-036 Reset then read r4,r5 -> rd_data 0,0, rd_busy 0,0, busy_cnt 0.
REQ-037 wr_en r7=0x0000_00A5 while rd_addr port0=7 -> next cycle rd_data[0]=0x0000_00A5 (bypass).
REQ-038 claim r3; next cycle read r3 -> rd_busy[0]=1, busy_cnt=1; write r3=0x11 -> busy clears, busy_cnt=0.
REQ-039 claim r3 twice consecutively -> claim_err=1 one cycle, busy_cnt stays 1; same-cycle claim+write r9 -> busy[9]=1, mem[9]=written data.
REQ-040 stall_flag=1 for 3 cycles while writing r2=0x22 and changing rd_addr -> rd_data/rd_busy unchanged; after release next read r2=0x22.
REQ-041 write r0=0xFFFF_FFFF and claim r0 (ZERO_REG=1) -> reads 0, busy 0, busy_cnt 0, claim_err 0; repeat with NUM_RD=4, DATA_W=64.
